i2c_transfer_sequencer: RTL and testbench
=========================================

Name: i2c_transfer_sequencer

Overview:
- Sequences one complete I2C master transfer from APB-programmed settings.
- Transfer: START, address byte, N data bytes, then STOP or a held bus for repeated start.
- Sits between the APB register block, the TX/RX FIFOs (PCLK-side ports) and the byte-level I2C core.
- Owns FIFO pop/push timing, master ACK/NACK generation, byte counting, and busy/done/error status.

Parameters:
DATA_W, 8, data byte width
CNT_W, 8, byte-count width (max transfer 2^CNT_W-1 bytes)

Ports:
PCLK  in  1  sole clock
PRESET  in  1  synchronous reset, active-high
go  in  1  one-cycle start request from command register
rw  in  1  0 = write, 1 = read
slave_addr  in  7  target address
byte_count  in  CNT_W  data bytes to transfer; 0 = address-only probe
repeated_start  in  1  1 = end without STOP and keep the bus
abort  in  1  one-cycle abort request
tx_empty  in  1  TX FIFO empty (first-word-fall-through)
tx_data  in  DATA_W  TX FIFO head
tx_pop  out  1  TX FIFO read increment
rx_full  in  1  RX FIFO full
rx_push  out  1  RX FIFO write enable
rx_data  out  DATA_W  RX FIFO write data
core_req  out  1  byte-command request to the I2C core
core_start  out  1  issue START/repeated START before this byte
core_stop  out  1  STOP-only command
core_read  out  1  read a byte (else write core_wdata)
core_mack  out  1  master ACK bit for a read: 0 = ACK, 1 = NACK
core_wdata  out  DATA_W  byte to transmit
core_done  in  1  one-cycle completion pulse from the core
core_nack  in  1  slave NACK; valid with core_done on writes
core_rdata  in  DATA_W  received byte; valid with core_done
busy  out  1  transfer in progress
done  out  1  one-cycle end-of-transfer pulse
error  out  2  00 ok, 01 address NACK, 10 data NACK, 11 aborted; sticky until next accepted go
remaining  out  CNT_W  data bytes still to transfer

Behaviour:
- Reset (synchronous, PRESET high at a PCLK edge):
  - All outputs go to 0 and the FSM goes to IDLE.
  - Applies mid-transfer: any outstanding core_req is dropped with no STOP issued.
  - The "bus held" flag clears.
- FSM states: IDLE, ADDR, TX_FETCH, TX_XFER, RX_XFER, RX_PUSH, STOP, DONE.
- Handshake:
  - core_req rises together with stable command outputs.
  - All core_* outputs hold until the cycle core_done=1; core_req drops the next cycle.
  - Exactly one core_done is consumed per core_req.
- IDLE:
  - go is ignored while busy=1.
  - On go, latch rw, slave_addr, byte_count and repeated_start into internal registers; set remaining=byte_count and busy=1; clear error.
  - Next cycle: ADDR with core_req=1, core_start=1, core_wdata={slave_addr,rw}.
  - Latency from go to core_req is 1 cycle.
- ADDR, on core_done:
  - core_nack=1: error=01, go to STOP.
  - byte_count=0: go to STOP (or DONE if repeated_start).
  - Otherwise go to TX_FETCH if rw=0, RX_XFER if rw=1.
- TX_FETCH:
  - Wait while tx_empty=1; no timeout.
  - When not empty: capture tx_data into core_wdata, pulse tx_pop for exactly 1 cycle, go to TX_XFER with core_req=1.
- TX_XFER, on core_done:
  - Decrement remaining.
  - core_nack=1: error=10, go to STOP.
  - remaining reaches 0: go to STOP (or DONE if repeated_start).
  - Otherwise go back to TX_FETCH.
- RX_XFER:
  - core_req=1, core_read=1.
  - core_mack=1 only when remaining=1 (last byte); otherwise 0.
  - On core_done: latch core_rdata into rx_data, go to RX_PUSH.
- RX_PUSH:
  - Wait while rx_full=1.
  - Then rx_push=1 for 1 cycle and decrement remaining.
  - remaining reaches 0: go to STOP (or DONE if repeated_start); otherwise RX_XFER.
  - The bus is never read ahead of RX FIFO space.
- STOP: core_req=1, core_stop=1; on core_done go to DONE. STOP is always issued after an error, even if repeated_start=1.
- DONE:
  - done=1 for 1 cycle, busy=0, then IDLE.
  - If ended without STOP, the bus-held flag is set; the next go's ADDR still asserts core_start (repeated START).
- abort:
  - Accepted in any non-IDLE state; error=11.
  - If core_req is outstanding, complete that handshake first, then go to STOP.
  - In TX_FETCH or RX_PUSH (no outstanding request), go straight to STOP; an RX byte not yet pushed is discarded.
  - abort in IDLE with the bus held: issue STOP, then DONE.
- go and abort in the same cycle while IDLE: abort wins; go is dropped.
- core_done arriving while core_req=0 is ignored.
- remaining never underflows: byte_count = 2^CNT_W-1 counts down to 0 exactly.

Test Plan:
- Write 3 bytes: go, rw=0, addr=0x50, count=3; FIFO holds A1,B2,C3 -> address byte 0xA0 with start; writes A1,B2,C3; 3 tx_pop pulses; STOP; done pulse; error=00.
- Read 2 with RX full: addr=0x3C, rw=1, count=2, rx_full=1 for 5 cycles after byte 1 -> byte 1 push stalls 5 cycles; core_mack=0 on byte 1, 1 on byte 2; 2 rx_push; second RX_XFER only after the first push.
- Address NACK: core_nack=1 on the address byte -> error=01; no tx_pop; STOP issued; done pulse.
- Repeated start: write count=1 with repeated_start=1, then read count=1 -> no STOP between transfers; second ADDR has core_start=1; single STOP at the end.
- Abort mid-write with TX FIFO empty in TX_FETCH -> immediate STOP; error=11; remaining holds its value.
- Reset mid RX_XFER: PRESET high for 1 cycle -> next cycle all outputs 0, state IDLE; a following go starts cleanly.

Source files
------------

// File: rtl/i2c_transfer_sequencer.sv
// Sequences one I2C master transfer (START, address, N data bytes, STOP or held bus)
// between APB settings, the PCLK-side TX/RX FIFO ports and a byte-level I2C core.
module i2c_transfer_sequencer #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 8
) (
  input  logic              PCLK,
  input  logic              PRESET,
  input  logic              go,
  input  logic              rw,
  input  logic [6:0]        slave_addr,
  input  logic [CNT_W-1:0]  byte_count,
  input  logic              repeated_start,
  input  logic              abort,
  input  logic              tx_empty,
  input  logic [DATA_W-1:0] tx_data,
  output logic              tx_pop,
  input  logic              rx_full,
  output logic              rx_push,
  output logic [DATA_W-1:0] rx_data,
  output logic              core_req,
  output logic              core_start,
  output logic              core_stop,
  output logic              core_read,
  output logic              core_mack,
  output logic [DATA_W-1:0] core_wdata,
  input  logic              core_done,
  input  logic              core_nack,
  input  logic [DATA_W-1:0] core_rdata,
  output logic              busy,
  output logic              done,
  output logic [1:0]        error,
  output logic [CNT_W-1:0]  remaining
);

  typedef enum logic [2:0] {
    IDLE, ADDR, TX_FETCH, TX_XFER, RX_XFER, RX_PUSH, STOP, DONE
  } state_t;

  state_t state, state_nx, end_state;
  logic   gap;         // one idle cycle after each consumed core_done
  logic   abort_pend;  // abort seen while a core request was outstanding
  logic   bus_held;
  logic   rw_r, rs_r;
  logic   req_done, aborting, go_acc, abort_acc;

  assign req_done  = core_req && core_done;
  assign aborting  = abort || abort_pend;
  assign go_acc    = (state == IDLE) && go && !abort;
  assign abort_acc = abort && (((state != IDLE) && (state != DONE)) ||
                               ((state == IDLE) && bus_held));
  assign end_state = rs_r ? DONE : STOP;

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state      <= IDLE;
      gap        <= 1'b0;
      abort_pend <= 1'b0;
      bus_held   <= 1'b0;
      rw_r       <= 1'b0;
      rs_r       <= 1'b0;
      remaining  <= '0;
      error      <= '0;
      core_wdata <= '0;
      rx_data    <= '0;
    end else begin
      state <= state_nx;
      gap   <= req_done;
      if (go_acc) begin
        rw_r       <= rw;
        rs_r       <= repeated_start;
        remaining  <= byte_count;
        error      <= '0;
        core_wdata <= DATA_W'({slave_addr, rw});
      end
      if (tx_pop)
        core_wdata <= tx_data;
      if (req_done && (state == RX_XFER))
        rx_data <= core_rdata;
      if ((req_done && (state == TX_XFER)) || rx_push)
        remaining <= remaining - CNT_W'(1);
      if (req_done && core_nack && !aborting) begin
        if (state == ADDR)
          error <= 2'b01;
        else if (state == TX_XFER)
          error <= 2'b10;
      end
      if (abort_acc)
        error <= 2'b11;
      // The pending abort is consumed once the FSM heads for STOP.
      if ((state inside {ADDR, TX_XFER, RX_XFER}) && core_req && abort)
        abort_pend <= 1'b1;
      if (state_nx == STOP)
        abort_pend <= 1'b0;
      if ((state_nx == DONE) && (state != STOP))
        bus_held <= 1'b1;
      if ((state == STOP) && req_done)
        bus_held <= 1'b0;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (abort && bus_held)
          state_nx = STOP;
        else if (go_acc)
          state_nx = ADDR;
      end
      ADDR: begin
        if (!core_req) begin
          if (aborting) state_nx = STOP;
        end else if (core_done) begin
          if (aborting || core_nack) state_nx = STOP;
          else if (remaining == '0)  state_nx = end_state;
          else if (rw_r)             state_nx = RX_XFER;
          else                       state_nx = TX_FETCH;
        end
      end
      TX_FETCH: begin
        if (aborting)
          state_nx = STOP;
        else if (!tx_empty)
          state_nx = TX_XFER;
      end
      TX_XFER: begin
        if (!core_req) begin
          if (aborting) state_nx = STOP;
        end else if (core_done) begin
          if (aborting || core_nack)         state_nx = STOP;
          else if (remaining == CNT_W'(1))   state_nx = end_state;
          else                               state_nx = TX_FETCH;
        end
      end
      RX_XFER: begin
        if (!core_req) begin
          if (aborting) state_nx = STOP;
        end else if (core_done) begin
          state_nx = aborting ? STOP : RX_PUSH;
        end
      end
      RX_PUSH: begin
        // A received byte that is not yet pushed is dropped on abort.
        if (aborting)
          state_nx = STOP;
        else if (!rx_full)
          state_nx = (remaining == CNT_W'(1)) ? end_state : RX_XFER;
      end
      STOP: begin
        if (req_done)
          state_nx = DONE;
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    core_req   = (state inside {ADDR, TX_XFER, RX_XFER, STOP}) && !gap;
    core_start = core_req && (state == ADDR);
    core_stop  = core_req && (state == STOP);
    core_read  = core_req && (state == RX_XFER);
    core_mack  = core_read && (remaining == CNT_W'(1));
    tx_pop     = (state == TX_FETCH) && !tx_empty && !aborting;
    rx_push    = (state == RX_PUSH) && !rx_full && !aborting;
    busy       = (state != IDLE) && (state != DONE);
    done       = (state == DONE);
  end

endmodule

// File: tb/tb_i2c_transfer_sequencer.sv
// Directed bench for i2c_transfer_sequencer with a behavioural I2C core and FIFO model.
module tb_i2c_transfer_sequencer;
  localparam int DATA_W = 8;
  localparam int CNT_W  = 8;

  logic              PCLK = 1'b0;
  logic              PRESET = 1'b1;
  logic              go = 1'b0, rw = 1'b0, repeated_start = 1'b0, abort = 1'b0;
  logic [6:0]        slave_addr = '0;
  logic [CNT_W-1:0]  byte_count = '0;
  logic              tx_empty = 1'b1, rx_full = 1'b0;
  logic [DATA_W-1:0] tx_data = '0;
  logic              core_done = 1'b0, core_nack = 1'b0;
  logic [DATA_W-1:0] core_rdata = '0;
  logic              tx_pop, rx_push, core_req, core_start, core_stop, core_read, core_mack;
  logic              busy, done;
  logic [DATA_W-1:0] rx_data, core_wdata;
  logic [1:0]        error;
  logic [CNT_W-1:0]  remaining;
  logic [34:0]       all_out;

  assign all_out = {busy, done, error, remaining, core_req, core_start, core_stop, core_read,
                    core_mack, core_wdata, tx_pop, rx_push, rx_data};

  i2c_transfer_sequencer #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .PCLK(PCLK), .PRESET(PRESET), .go(go), .rw(rw), .slave_addr(slave_addr),
    .byte_count(byte_count), .repeated_start(repeated_start), .abort(abort),
    .tx_empty(tx_empty), .tx_data(tx_data), .tx_pop(tx_pop), .rx_full(rx_full),
    .rx_push(rx_push), .rx_data(rx_data), .core_req(core_req), .core_start(core_start),
    .core_stop(core_stop), .core_read(core_read), .core_mack(core_mack),
    .core_wdata(core_wdata), .core_done(core_done), .core_nack(core_nack),
    .core_rdata(core_rdata), .busy(busy), .done(done), .error(error), .remaining(remaining)
  );

  initial forever #5 PCLK = ~PCLK;

  int n_cmp = 0, n_err = 0;
  int cyc = 0, pop_cnt = 0, done_cnt = 0, core_lat = 2;
  logic nack_addr = 1'b0;
  logic [7:0]  tx_q[$], rd_q[$], pushes[$];
  logic [11:0] cmds[$];   // {start, stop, read, mack, wdata}
  int push_cyc[$], rd_done_cyc[$], rd_rise_cyc[$];

  // Core responder, FIFO model and event log: samples at negedge, drives 1ns after posedge.
  initial begin : env
    int wait_cnt;
    logic do_done, do_pop, req_prev, nk;
    logic [7:0] rd_val;
    wait_cnt = 0;
    req_prev = 1'b0;
    forever begin
      @(negedge PCLK);
      cyc++;
      do_done = 1'b0; do_pop = tx_pop; nk = 1'b0; rd_val = 8'h00;
      if (tx_pop) pop_cnt++;
      if (rx_push) begin pushes.push_back(rx_data); push_cyc.push_back(cyc); end
      if (done) done_cnt++;
      if (core_done && core_read) rd_done_cyc.push_back(cyc);
      if (core_req && !req_prev && core_read) rd_rise_cyc.push_back(cyc);
      if (!core_req) wait_cnt = 0;
      else if (!core_done) begin
        wait_cnt++;
        if (wait_cnt >= core_lat) begin
          do_done = 1'b1;
          wait_cnt = 0;
          cmds.push_back({core_start, core_stop, core_read, core_mack,
                          (core_read || core_stop) ? 8'h00 : core_wdata});
          nk = core_start && nack_addr;
          if (core_read) begin
            if (rd_q.size() > 0) rd_val = rd_q.pop_front();
            else rd_val = 8'hEE;
          end
        end
      end
      req_prev = core_req;
      @(posedge PCLK); #1;
      core_done = do_done; core_nack = nk; core_rdata = rd_val;
      if (do_pop && tx_q.size() > 0) void'(tx_q.pop_front());
      tx_empty = (tx_q.size() == 0);
      tx_data  = tx_empty ? 8'h00 : tx_q[0];
    end
  end

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic clear_logs();
    @(posedge PCLK); #2;
    cmds.delete(); pushes.delete(); tx_q.delete(); rd_q.delete();
    push_cyc.delete(); rd_done_cyc.delete(); rd_rise_cyc.delete();
    pop_cnt = 0; done_cnt = 0;
  endtask

  task automatic pulse_go(input logic r, input logic [6:0] a, input logic [7:0] n, input logic rs);
    @(posedge PCLK); #1;
    rw = r; slave_addr = a; byte_count = n; repeated_start = rs; go = 1'b1;
    @(posedge PCLK); #1;
    go = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge PCLK);
      if (done) seen = 1'b1;
    end
  endtask

  task automatic test_reset();
    @(negedge PCLK);
    n_cmp++; if (all_out !== '0) begin n_err++; $display("FAIL reset_outputs got=%h exp=0", all_out); end
    @(posedge PCLK); #1; PRESET = 1'b0;
    repeat (2) @(negedge PCLK);
    n_cmp++; if (all_out !== '0) begin n_err++; $display("FAIL reset_idle_outputs got=%h exp=0", all_out); end
  endtask

  task automatic test_write3();
    logic [11:0] exp_cmd[$], got;
    bit seen;
    clear_logs();
    tx_q = '{8'hA1, 8'hB2, 8'hC3};
    pulse_go(1'b0, 7'h50, 8'd3, 1'b0);
    @(negedge PCLK);
    n_cmp++; if ({core_req, core_start, busy} !== 3'b111) begin n_err++; $display("FAIL write3_addr_req got=%b exp=111", {core_req, core_start, busy}); end
    n_cmp++; if (core_wdata !== 8'hA0) begin n_err++; $display("FAIL write3_addr_byte got=%h exp=a0", core_wdata); end
    n_cmp++; if (remaining !== 8'd3) begin n_err++; $display("FAIL write3_remaining_start got=%0d exp=3", remaining); end
    wait_done(200, seen);
    n_cmp++; if (seen !== 1'b1) begin n_err++; $display("FAIL write3_done_seen got=%0b exp=1", seen); end
    n_cmp++; if ({error, busy} !== 3'b000) begin n_err++; $display("FAIL write3_status got=%b exp=000", {error, busy}); end
    repeat (3) @(negedge PCLK);
    exp_cmd = '{12'h8A0, 12'h0A1, 12'h0B2, 12'h0C3, 12'h400};
    n_cmp++; if (cmds.size() != exp_cmd.size()) begin n_err++; $display("FAIL write3_cmd_count got=%0d exp=%0d", cmds.size(), exp_cmd.size()); end
    foreach (exp_cmd[i]) begin
      got = (i < cmds.size()) ? cmds[i] : 12'hFFF;
      n_cmp++; if (got !== exp_cmd[i]) begin n_err++; $display("FAIL write3_cmd[%0d] got=%h exp=%h", i, got, exp_cmd[i]); end
    end
    n_cmp++; if (pop_cnt != 3) begin n_err++; $display("FAIL write3_pops got=%0d exp=3", pop_cnt); end
    n_cmp++; if (done_cnt != 1) begin n_err++; $display("FAIL write3_done_pulses got=%0d exp=1", done_cnt); end
    n_cmp++; if (remaining !== 8'd0) begin n_err++; $display("FAIL write3_remaining_end got=%0d exp=0", remaining); end
  endtask

  task automatic test_read_rx_full();
    logic [11:0] exp_cmd[$], got;
    bit seen;
    int d1, d2;
    clear_logs();
    rd_q = '{8'h5A, 8'hA5};
    pulse_go(1'b1, 7'h3C, 8'd2, 1'b0);
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge PCLK);
      if (core_done && core_read) seen = 1'b1;
    end
    n_cmp++; if (seen !== 1'b1) begin n_err++; $display("FAIL read2_first_byte got=%0b exp=1", seen); end
    @(posedge PCLK); #1; rx_full = 1'b1;
    repeat (5) @(posedge PCLK);
    #1; rx_full = 1'b0;
    wait_done(200, seen);
    n_cmp++; if (seen !== 1'b1) begin n_err++; $display("FAIL read2_done_seen got=%0b exp=1", seen); end
    n_cmp++; if (error !== 2'b00) begin n_err++; $display("FAIL read2_error got=%b exp=00", error); end
    repeat (3) @(negedge PCLK);
    exp_cmd = '{12'h879, 12'h200, 12'h300, 12'h400};
    n_cmp++; if (cmds.size() != exp_cmd.size()) begin n_err++; $display("FAIL read2_cmd_count got=%0d exp=%0d", cmds.size(), exp_cmd.size()); end
    foreach (exp_cmd[i]) begin
      got = (i < cmds.size()) ? cmds[i] : 12'hFFF;
      n_cmp++; if (got !== exp_cmd[i]) begin n_err++; $display("FAIL read2_cmd[%0d] got=%h exp=%h", i, got, exp_cmd[i]); end
    end
    n_cmp++; if (pushes.size() != 2) begin n_err++; $display("FAIL read2_push_count got=%0d exp=2", pushes.size()); end
    n_cmp++; if ((pushes.size() > 1 ? {pushes[0], pushes[1]} : 16'hFFFF) !== 16'h5AA5) begin n_err++; $display("FAIL read2_push_data got=%h exp=5aa5", (pushes.size() > 1 ? {pushes[0], pushes[1]} : 16'hFFFF)); end
    d1 = (push_cyc.size() > 0 && rd_done_cyc.size() > 0) ? push_cyc[0] - rd_done_cyc[0] : -1;
    d2 = (push_cyc.size() > 0 && rd_rise_cyc.size() > 1) ? rd_rise_cyc[1] - push_cyc[0] : -1;
    n_cmp++; if (d1 != 6) begin n_err++; $display("FAIL read2_push_stall got=%0d exp=6", d1); end
    n_cmp++; if (d2 <= 0) begin n_err++; $display("FAIL read2_read_after_push got=%0d exp=>0", d2); end
  endtask

  task automatic test_addr_nack();
    logic [11:0] exp_cmd[$], got;
    bit seen;
    clear_logs();
    nack_addr = 1'b1;
    tx_q = '{8'h11, 8'h22};
    pulse_go(1'b0, 7'h22, 8'd2, 1'b0);
    wait_done(200, seen);
    n_cmp++; if (seen !== 1'b1) begin n_err++; $display("FAIL nack_done_seen got=%0b exp=1", seen); end
    n_cmp++; if (error !== 2'b01) begin n_err++; $display("FAIL nack_error got=%b exp=01", error); end
    repeat (3) @(negedge PCLK);
    nack_addr = 1'b0;
    exp_cmd = '{12'h844, 12'h400};
    n_cmp++; if (cmds.size() != exp_cmd.size()) begin n_err++; $display("FAIL nack_cmd_count got=%0d exp=%0d", cmds.size(), exp_cmd.size()); end
    foreach (exp_cmd[i]) begin
      got = (i < cmds.size()) ? cmds[i] : 12'hFFF;
      n_cmp++; if (got !== exp_cmd[i]) begin n_err++; $display("FAIL nack_cmd[%0d] got=%h exp=%h", i, got, exp_cmd[i]); end
    end
    n_cmp++; if (pop_cnt != 0) begin n_err++; $display("FAIL nack_pops got=%0d exp=0", pop_cnt); end
    n_cmp++; if (done_cnt != 1) begin n_err++; $display("FAIL nack_done_pulses got=%0d exp=1", done_cnt); end
  endtask

  task automatic test_repeated_start();
    logic [11:0] exp_cmd[$], got;
    bit seen;
    int stops;
    clear_logs();
    tx_q = '{8'h77};
    pulse_go(1'b0, 7'h10, 8'd1, 1'b1);
    wait_done(200, seen);
    n_cmp++; if (seen !== 1'b1) begin n_err++; $display("FAIL rs_first_done got=%0b exp=1", seen); end
    repeat (3) @(negedge PCLK);
    rd_q = '{8'hC4};
    pulse_go(1'b1, 7'h11, 8'd1, 1'b0);
    @(negedge PCLK);
    n_cmp++; if ({core_req, core_start, core_wdata} !== 10'b11_0010_0011) begin n_err++; $display("FAIL rs_second_addr got=%b exp=1100100011", {core_req, core_start, core_wdata}); end
    wait_done(200, seen);
    n_cmp++; if (seen !== 1'b1) begin n_err++; $display("FAIL rs_second_done got=%0b exp=1", seen); end
    repeat (3) @(negedge PCLK);
    exp_cmd = '{12'h820, 12'h077, 12'h823, 12'h300, 12'h400};
    n_cmp++; if (cmds.size() != exp_cmd.size()) begin n_err++; $display("FAIL rs_cmd_count got=%0d exp=%0d", cmds.size(), exp_cmd.size()); end
    foreach (exp_cmd[i]) begin
      got = (i < cmds.size()) ? cmds[i] : 12'hFFF;
      n_cmp++; if (got !== exp_cmd[i]) begin n_err++; $display("FAIL rs_cmd[%0d] got=%h exp=%h", i, got, exp_cmd[i]); end
    end
    stops = 0;
    foreach (cmds[i]) if (cmds[i][10]) stops++;
    n_cmp++; if (stops != 1) begin n_err++; $display("FAIL rs_stop_count got=%0d exp=1", stops); end
    n_cmp++; if ((pushes.size() > 0 ? pushes[0] : 8'hFF) !== 8'hC4) begin n_err++; $display("FAIL rs_rx_data got=%h exp=c4", (pushes.size() > 0 ? pushes[0] : 8'hFF)); end
    n_cmp++; if (done_cnt != 2) begin n_err++; $display("FAIL rs_done_pulses got=%0d exp=2", done_cnt); end
  endtask

  task automatic test_abort_tx_fetch();
    bit seen;
    clear_logs();
    pulse_go(1'b0, 7'h33, 8'd255, 1'b0);
    @(negedge PCLK);
    n_cmp++; if (remaining !== 8'd255) begin n_err++; $display("FAIL abort_remaining_max got=%0d exp=255", remaining); end
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge PCLK);
      if (core_done) seen = 1'b1;
    end
    n_cmp++; if (seen !== 1'b1) begin n_err++; $display("FAIL abort_addr_done got=%0b exp=1", seen); end
    repeat (4) @(posedge PCLK);
    #1; abort = 1'b1;
    @(posedge PCLK); #1; abort = 1'b0;
    @(negedge PCLK);
    n_cmp++; if ({core_req, core_stop, busy} !== 3'b111) begin n_err++; $display("FAIL abort_immediate_stop got=%b exp=111", {core_req, core_stop, busy}); end
    n_cmp++; if (error !== 2'b11) begin n_err++; $display("FAIL abort_error got=%b exp=11", error); end
    wait_done(200, seen);
    n_cmp++; if (seen !== 1'b1) begin n_err++; $display("FAIL abort_done_seen got=%0b exp=1", seen); end
    repeat (3) @(negedge PCLK);
    n_cmp++; if (remaining !== 8'd255) begin n_err++; $display("FAIL abort_remaining_held got=%0d exp=255", remaining); end
    n_cmp++; if (pop_cnt != 0) begin n_err++; $display("FAIL abort_pops got=%0d exp=0", pop_cnt); end
    n_cmp++; if ((cmds.size() == 2 ? {cmds[0], cmds[1]} : 24'hFFFFFF) !== 24'h866400) begin n_err++; $display("FAIL abort_cmds got=%0d entries exp=866,400", cmds.size()); end
  endtask

  task automatic test_go_abort_idle();
    clear_logs();
    @(posedge PCLK); #1;
    rw = 1'b0; slave_addr = 7'h12; byte_count = 8'd1; repeated_start = 1'b0;
    go = 1'b1; abort = 1'b1;
    @(posedge PCLK); #1; go = 1'b0; abort = 1'b0;
    repeat (2) @(negedge PCLK);
    n_cmp++; if ({busy, core_req} !== 2'b00) begin n_err++; $display("FAIL goabort_idle got=%b exp=00", {busy, core_req}); end
    n_cmp++; if (error !== 2'b11) begin n_err++; $display("FAIL goabort_error_kept got=%b exp=11", error); end
  endtask

  task automatic test_reset_mid_rx();
    logic [11:0] exp_cmd[$], got;
    bit seen;
    clear_logs();
    core_lat = 8;
    rd_q = '{8'h99, 8'h98};
    pulse_go(1'b1, 7'h40, 8'd2, 1'b0);
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge PCLK);
      if (core_req && core_read) seen = 1'b1;
    end
    n_cmp++; if (seen !== 1'b1) begin n_err++; $display("FAIL midrx_reach_read got=%0b exp=1", seen); end
    @(posedge PCLK); #1; PRESET = 1'b1;
    @(posedge PCLK); #1; PRESET = 1'b0;
    @(negedge PCLK);
    n_cmp++; if (all_out !== '0) begin n_err++; $display("FAIL midrx_reset_outputs got=%h exp=0", all_out); end
    core_lat = 2;
    clear_logs();
    tx_q = '{8'h5E};
    pulse_go(1'b0, 7'h41, 8'd1, 1'b0);
    @(negedge PCLK);
    n_cmp++; if ({core_req, core_start, core_wdata} !== 10'b11_1000_0010) begin n_err++; $display("FAIL midrx_restart_addr got=%b exp=1110000010", {core_req, core_start, core_wdata}); end
    wait_done(200, seen);
    n_cmp++; if ({seen, error} !== 3'b100) begin n_err++; $display("FAIL midrx_restart_done got=%b exp=100", {seen, error}); end
    repeat (3) @(negedge PCLK);
    exp_cmd = '{12'h882, 12'h05E, 12'h400};
    n_cmp++; if (cmds.size() != exp_cmd.size()) begin n_err++; $display("FAIL midrx_cmd_count got=%0d exp=%0d", cmds.size(), exp_cmd.size()); end
    foreach (exp_cmd[i]) begin
      got = (i < cmds.size()) ? cmds[i] : 12'hFFF;
      n_cmp++; if (got !== exp_cmd[i]) begin n_err++; $display("FAIL midrx_cmd[%0d] got=%h exp=%h", i, got, exp_cmd[i]); end
    end
    n_cmp++; if (pop_cnt != 1) begin n_err++; $display("FAIL midrx_pops got=%0d exp=1", pop_cnt); end
  endtask

  initial begin : main
    test_reset();
    test_write3();
    test_read_rx_full();
    test_addr_nack();
    test_repeated_start();
    test_abort_tx_fetch();
    test_go_abort_idle();
    test_reset_mid_rx();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
